dds_multiwave: RTL and testbench

DDS_MULTIWAVE -- requirements
Module: dds_multiwave

---
 rtl/dds_multiwave.sv | 149 ++++++++++++++
 tb/tb_dds_multiwave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multiwave.sv
// Multi-waveform DDS: phase accumulator, two-stage waveform pipeline and key-driven frequency stepping.
// Define DDS_KEY_DEBOUNCE_EN to require DEB_CYC stable cycles on the synchronised key before a step.
module dds_multiwave #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned FSTEP   = 32'd16777216,
  parameter int unsigned STEPS   = 8,
  parameter int unsigned DEB_CYC = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               choose,
  input  logic                     key_s4,
  input  logic                     sync_clr,
  output logic [OUT_W-1:0]         out_wave,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     cycle_tick
);

  localparam int unsigned SW   = $clog2(STEPS);
  localparam int          NPH  = 1 << OUT_W;
  localparam int          MIDV = 1 << (OUT_W - 1);
  localparam int          AMP  = MIDV - 1;

  // Elaboration-time sine sample: round(AMP*sin(2*pi*idx/NPH)) + MIDV, Taylor series on [-pi, pi].
  function automatic int sine_val(input int idx);
    real pi, x, term, sum;
    pi = 3.14159265358979323846;
    x  = 2.0 * pi * $itor(idx) / $itor(NPH);
    if (x > pi) x = x - 2.0 * pi;
    term = x;
    sum  = x;
    for (int k = 1; k < 20; k++) begin
      term = -term * x * x / $itor((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    sum = sum * $itor(AMP);
    if (sum >= 0.0) return MIDV + $rtoi(sum + 0.5);
    return MIDV - $rtoi(0.5 - sum);
  endfunction

  logic [OUT_W-1:0] sine_lut [NPH];

  for (genvar gi = 0; gi < NPH; gi++) begin : g_lut
    localparam int SINE_V = sine_val(gi);
    assign sine_lut[gi] = OUT_W'(SINE_V);
  end

  logic [ACC_W-1:0] acc_q, acc_d, fw_c, sum_c;
  logic             carry_c;
  logic             tick_q, tick_d;
  logic [SW-1:0]    step_q, step_d;
  logic             key_meta_q, key_sync_q, key_prev_q, key_lvl_c, step_c;
  logic [OUT_W-1:0] ph_q;
  logic [2:0]       ch_q;
  logic             vld_q;
  logic [OUT_W-1:0] out_q, out_d, wave_c;

`ifdef DDS_KEY_DEBOUNCE_EN
  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_q, deb_d;

  // Accept a new key level only once it has differed from the accepted level for DEB_CYC cycles.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (key_sync_q != deb_q) begin
      if (deb_cnt_q == CW'(DEB_CYC - 1)) deb_d = key_sync_q;
      else                               deb_cnt_d = deb_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign key_lvl_c = deb_q;
`else
  // DEB_CYC has no effect in this build.
  if (DEB_CYC == 0) begin : g_deb_unused
  end

  assign key_lvl_c = key_sync_q;
`endif

  assign step_c = key_lvl_c & ~key_prev_q;
  assign fw_c   = ACC_W'(64'(FSTEP) * (64'(step_q) + 64'd1));
  assign {carry_c, sum_c} = {1'b0, acc_q} + {1'b0, fw_c};

  // Waveform shaping from the pipelined phase and select.
  always_comb begin
    wave_c = OUT_W'(MIDV);
    case (ch_q)
      3'b000:  wave_c = sine_lut[ph_q];
      3'b001:  wave_c = ph_q[OUT_W-1] ? '0 : '1;
      3'b010:  wave_c = ph_q[OUT_W-1] ? ~{ph_q[OUT_W-2:0], 1'b0} : {ph_q[OUT_W-2:0], 1'b0};
      3'b011:  wave_c = ph_q;
      3'b100:  wave_c = ~ph_q;
      default: wave_c = OUT_W'(MIDV);
    endcase
  end

  always_comb begin
    acc_d  = sync_clr ? '0 : sum_c;
    tick_d = carry_c & ~sync_clr;
    step_d = step_q;
    if (step_c) step_d = (step_q == SW'(STEPS - 1)) ? '0 : step_q + SW'(1);
    out_d  = vld_q ? wave_c : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      tick_q     <= 1'b0;
      step_q     <= '0;
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
      ph_q       <= '0;
      ch_q       <= '0;
      vld_q      <= 1'b0;
      out_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      tick_q     <= tick_d;
      step_q     <= step_d;
      key_meta_q <= key_s4;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_lvl_c;
      ph_q       <= acc_q[ACC_W-1 -: OUT_W];
      ch_q       <= choose;
      vld_q      <= 1'b1;
      out_q      <= out_d;
    end
  end

  assign out_wave   = out_q;
  assign step_idx   = step_q;
  assign cycle_tick = tick_q;

endmodule

// File: tb/tb_dds_multiwave.sv
// Self-checking bench for dds_multiwave: behavioural model compared every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_dds_multiwave;

  localparam int  DEB = 16;
  localparam real PI  = 3.14159265358979323846;

  logic       clk;
  logic       reset;
  logic [2:0] choose;
  logic       key_s4;
  logic       sync_clr;
  logic [7:0] out_wave;
  logic [2:0] step_idx;
  logic       cycle_tick;

  int n_tests = 0;
  int n_fail  = 0;

  dds_multiwave #(
    .ACC_W(32), .OUT_W(8), .FSTEP(32'd16777216), .STEPS(8), .DEB_CYC(DEB)
  ) dut (
    .clk(clk), .reset(reset), .choose(choose), .key_s4(key_s4), .sync_clr(sync_clr),
    .out_wave(out_wave), .step_idx(step_idx), .cycle_tick(cycle_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wave_f(input int ph, input int ch);
    real s;
    case (ch)
      0: begin
        s = 127.0 * $sin(2.0 * PI * $itor(ph) / 256.0);
        return (s >= 0.0) ? 128 + $rtoi(s + 0.5) : 128 - $rtoi(0.5 - s);
      end
      1: return (ph < 128) ? 255 : 0;
      2: return (ph < 128) ? ((ph * 2) & 255) : 255 - ((ph * 2) & 255);
      3: return ph;
      4: return 255 - ph;
      default: return 128;
    endcase
  endfunction

  // Reference model state
  longint m_acc = 0;
  int     m_step = 0, p_ph = 0, p_ch = 0, e_out = 0, e_step = 0, run = 0;
  bit     pv = 0, e_tick = 0, lvl1 = 0, lvl2 = 0, k_prev = 0, run_val = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_acc = 0; m_step = 0; pv = 0; p_ph = 0; p_ch = 0;
      e_out = 0; e_step = 0; e_tick = 0;
      lvl1 = 0; lvl2 = 0; k_prev = 0; run_val = 0; run = 0;
    end else begin
      longint sum;
      bit step_now, lvl_n;
      // Output shows the phase/select seen two edges ago.
      e_out = pv ? wave_f(p_ph, p_ch) : 0;
      pv    = 1;
      p_ph  = int'(m_acc >> 24);
      p_ch  = int'(choose);
      sum    = m_acc + (longint'(1) << 24) * longint'(m_step + 1);
      e_tick = !sync_clr && (sum >= (longint'(1) << 32));
      m_acc  = sync_clr ? 0 : (sum & 64'hFFFF_FFFF);
      // Key: synchronised value is the sample from the previous edge; step on level rise.
      step_now = lvl1 && !lvl2;
`ifdef DDS_KEY_DEBOUNCE_EN
      lvl_n = (run >= DEB) ? run_val : lvl1;
      if (k_prev == run_val) run++;
      else begin run_val = k_prev; run = 1; end
`else
      lvl_n = k_prev;
`endif
      lvl2   = lvl1;
      lvl1   = lvl_n;
      k_prev = key_s4;
      if (step_now) m_step = (m_step + 1) % 8;
      e_step = m_step;
    end
  end

  always @(negedge clk) begin
    chk("out_wave", out_wave, e_out);
    chk("step_idx", step_idx, e_step);
    chk("cycle_tick", cycle_tick, e_tick);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int rel);
    key_s4 = 1'b1; cyc(hold);
    key_s4 = 1'b0; cyc(rel);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: run still going at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int saw_exp [5];
    int first_tick, a, b, lat, exp_step, kcnt;
    saw_exp = '{0, 0, 1, 2, 3};
    reset = 1'b1; choose = 3'd3; key_s4 = 1'b0; sync_clr = 1'b0;
    #1 reset = 1'b0;
    cyc(3);
    chk("reset_out", out_wave, 0);
    chk("reset_step", step_idx, 0);
    reset = 1'b1;

    // Sawtooth after reset and first wrap tick
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("saw_start", out_wave, saw_exp[i]);
    end
    first_tick = -1;
    for (int n = 6; n <= 600 && first_tick < 0; n++) begin
      cyc(1);
      if (cycle_tick) first_tick = n;
    end
    chk("first_tick", first_tick, 256);

    // Square from a cleared phase
    sync_clr = 1'b1; choose = 3'd1;
    cyc(1);
    sync_clr = 1'b0;
    chk("clr_no_tick", cycle_tick, 0);
    cyc(2);  chk("square_hi_first", out_wave, 255);
    cyc(127); chk("square_hi_last", out_wave, 255);
    cyc(1);  chk("square_lo_first", out_wave, 0);
    cyc(127); chk("square_lo_last", out_wave, 0);

    choose = 3'd7;
    cyc(2); chk("midscale", out_wave, 128);

    // Random select and clear, no key
    for (int i = 0; i < 400; i++) begin
      choose   = 3'($urandom_range(0, 7));
      sync_clr = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    sync_clr = 1'b0; choose = 3'd3;
    cyc(3);

    // Single step from a held (bouncy) press; slope doubles
`ifdef DDS_KEY_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) press(5, 5);
`endif
    press(40, 40);
    chk("one_step", step_idx, 1);
    cyc(1); a = out_wave;
    cyc(1); b = out_wave;
    chk("slope_x2", (b - a) & 255, 2);

    // Clean presses walk through all steps and wrap
    exp_step = 1;
    for (int i = 0; i < 7; i++) begin
      press(DEB + 8, DEB + 8);
      exp_step = (exp_step + 1) % 8;
      chk("press_step", step_idx, exp_step);
    end

    // Step and phase clear on the same edge
`ifdef DDS_KEY_DEBOUNCE_EN
    lat = DEB + 3;
`else
    lat = 3;
`endif
    key_s4 = 1'b1;
    cyc(lat - 1);
    sync_clr = 1'b1;
    cyc(1);
    sync_clr = 1'b0;
    chk("clr_step", step_idx, 1);
    cyc(2);
    chk("clr_out", out_wave, 0);
    key_s4 = 1'b0;
    cyc(DEB + 10);

    // Reset mid-debounce with sine selected
    choose = 3'd0; key_s4 = 1'b1;
    cyc(5);
    #2 reset = 1'b0;
    #1;
    chk("async_out", out_wave, 0);
    chk("async_step", step_idx, 0);
    chk("async_tick", cycle_tick, 0);
    key_s4 = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("sine_restart", out_wave, 128);
    chk("restart_step", step_idx, 0);
    cyc(DEB + 10);
    chk("no_ghost_step", step_idx, 0);

    // Random key, select and clear
    kcnt = 0;
    for (int i = 0; i < 2500; i++) begin
      if (kcnt == 0) begin
        key_s4 = ~key_s4;
        kcnt = $urandom_range(1, 40);
      end else kcnt--;
      if ($urandom_range(0, 7) == 0) choose = 3'($urandom_range(0, 7));
      sync_clr = ($urandom_range(0, 31) == 0);
      cyc(1);
    end
    key_s4 = 1'b0; sync_clr = 1'b0;
    cyc(DEB + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
